// File: rtl/imem_line_responder_pkg.sv
// Shared definitions for the instruction-memory line responder: FSM encoding and the
// bubble word that decode can reuse when inserting NOPs.
package imem_line_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } imem_state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_line_store.sv
// Word storage for the single buffered line: one write port driven by the fill beats,
// one combinational read port indexed by the fetch offset.
module imem_line_store #(
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [OFF_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [OFF_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] words [LINE_WORDS];

    // Contents are deliberately not reset; line_valid in the parent guards every read.
    always_ff @(posedge clk) begin
        if (we) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_data = words[rd_idx];

endmodule

// File: rtl/imem_line_responder.sv
// Fetch-side instruction memory responder backed by one line buffer, refilled over a
// valid/ready request and beat-per-word response bus.
//
// state   | meaning
// IDLE    | serving hits; a miss latches the line tag and launches a fill
// REQ     | line-fill request held on the bus until accepted
// FILL    | collecting response beats in ascending word order
module imem_line_responder
    import imem_line_responder_pkg::*;
#(
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] im_addr,
    output logic [31:0] im_data,
    output logic        im_miss,
    input  logic        invalidate,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 32 - OFF_W;

    imem_state_e      state, state_nxt;
    logic             line_valid;
    logic             inv_pending;
    logic [TAG_W-1:0] line_tag;
    logic [TAG_W-1:0] fill_tag;
    logic [OFF_W-1:0] beat_cnt;

    logic [TAG_W-1:0] tag;
    logic [OFF_W-1:0] offset;
    logic             hit;
    logic             last_beat;
    logic             store_we;
    logic [31:0]      rd_data;

    assign tag       = im_addr[31:OFF_W];
    assign offset    = im_addr[OFF_W-1:0];
    assign hit       = line_valid && (tag == line_tag);
    assign last_beat = (beat_cnt == OFF_W'(LINE_WORDS - 1));
    assign store_we  = (state == ST_FILL) && mem_rsp_valid;

    imem_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W)
    ) u_store (
        .clk     (clk),
        .we      (store_we),
        .wr_idx  (beat_cnt),
        .wr_data (mem_rsp_data),
        .rd_idx  (offset),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt     = state;
        im_data       = NOP_WORD;
        im_miss       = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        if (hit) begin
            im_data = rd_data;
            im_miss = 1'b0;
        end
        case (state)
            ST_IDLE: begin
                if (!hit && !invalidate) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {fill_tag, {OFF_W{1'b0}}};
                if (mem_req_ready) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_rsp_valid && last_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            line_valid  <= 1'b0;
            inv_pending <= 1'b0;
            beat_cnt    <= '0;
            line_tag    <= '0;
            fill_tag    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (invalidate) begin
                        line_valid <= 1'b0;
                    end else if (!hit) begin
                        fill_tag   <= tag;
                        line_valid <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (invalidate) begin
                        inv_pending <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        beat_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (invalidate) begin
                        inv_pending <= 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // A fence.i landing on the final beat still poisons the line.
                        if (last_beat) begin
                            line_tag    <= fill_tag;
                            line_valid  <= !(inv_pending || invalidate);
                            inv_pending <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_line_responder.sv
// Randomized and directed bench for imem_line_responder: a bus responder feeds fills from
// a reference memory, and a monitor retires expected fetch results from a scoreboard queue.
module tb_imem_line_responder;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        im_miss;
    logic        invalidate;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;
    fetch_t sb_q[$];

    imem_line_responder #(.LINE_WORDS(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .im_addr       (im_addr),
        .im_data       (im_data),
        .im_miss       (im_miss),
        .invalidate    (invalidate),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    always #5 clk = ~clk;

    // Backing memory: words 0..3 hold 0x11..0x44, everything else a hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < LW) return (a + 32'd1) * 32'h11;
        return a * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever the DUT reports a hit and a fetch is outstanding, retire it.
    always @(posedge clk) begin
        #3;
        if (sb_q.size() > 0 && im_miss === 1'b0) begin
            fetch_t e;
            e = sb_q.pop_front();
            checks++;
            if (im_data !== e.data) begin
                failures++;
                $display("FAIL fetch_data addr=%h actual=%h required=%h", e.addr, im_data, e.data);
            end
        end
    end

    task automatic wait_pop(input int bound);
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < bound) begin
            step();
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout addr=%h actual=miss required=hit", sb_q[0].addr);
            sb_q.delete();
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_t e;
        im_addr = a;
        e.addr  = a;
        e.data  = mem_word(a);
        sb_q.push_back(e);
        wait_pop(3);
    endtask

    // Bus responder for one line fill. Entered at posedge+1 (or later in that cycle);
    // returns at posedge+1 of the cycle after the last beat.
    task automatic serve(input logic [31:0] base, input int rdly, input int gmax,
                         input int redir_k, input logic [31:0] redir_addr,
                         input int inv_k, output int waited);
        waited = 0;
        #1;
        while (!mem_req_valid && waited < 40) begin
            step();
            #1;
            waited++;
        end
        if (!mem_req_valid) begin
            checks++;
            failures++;
            $display("FAIL req_timeout base=%h actual=idle required=request", base);
            return;
        end
        check("req_addr", mem_req_addr, base);
        for (int d = 0; d < rdly; d++) begin
            step();
            #1;
            check("req_hold_valid", {31'd0, mem_req_valid}, 32'd1);
            check("req_hold_addr", mem_req_addr, base);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("req_drop", {31'd0, mem_req_valid}, 32'd0);
        for (int k = 0; k < LW; k++) begin
            int g;
            g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
            repeat (g) begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = 32'hDEAD_BEEF;
                step();
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(base + k);
            if (k == redir_k) im_addr = redir_addr;
            if (k == inv_k) invalidate = 1'b1;
            #1;
            check("fill_miss", {31'd0, im_miss}, 32'd1);
            step();
            invalidate = 1'b0;
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        logic        model_valid;
        logic [31:0] model_line;
        logic [31:0] a;

        rst           = 1'b1;
        im_addr       = 32'd0;
        invalidate    = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        repeat (2) step();
        rst = 1'b0;

        // Post-reset fetch and cold fill with back-to-back beats.
        #1;
        check("rst_miss", {31'd0, im_miss}, 32'd1);
        check("rst_nop", im_data, 32'h0000_0013);
        check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_req_addr", mem_req_addr, 32'd0);
        serve(32'd0, 0, 0, -1, 32'd0, -1, w);
        check("cold_req_latency", w, 32'd1);
        #1;
        check("cold_hit_latency", {31'd0, im_miss}, 32'd0);
        for (int i = 0; i < LW; i++) fetch(i);

        // Ready held off and gapped beats.
        im_addr = 32'd9;
        serve(32'd8, 3, 2, -1, 32'd0, -1, w);
        fetch(32'd9);
        fetch(32'd8);
        fetch(32'd11);

        // Redirect to 20 while line 0 is filling.
        im_addr = 32'd0;
        serve(32'd0, 0, 1, 2, 32'd20, -1, w);
        #1;
        check("redir_miss", {31'd0, im_miss}, 32'd1);
        im_addr = 32'd0;
        #1;
        check("redir_line0_hit", {31'd0, im_miss}, 32'd0);
        check("redir_line0_data", im_data, mem_word(32'd0));
        im_addr = 32'd20;
        serve(32'd20, 1, 1, -1, 32'd0, -1, w);
        check("redir_relaunch", w, 32'd1);
        fetch(32'd20);
        fetch(32'd23);

        // fence.i during a fill forces a refetch of the same base.
        im_addr = 32'd32;
        serve(32'd32, 1, 1, -1, 32'd0, 1, w);
        #1;
        check("inv_fill_miss", {31'd0, im_miss}, 32'd1);
        serve(32'd32, 0, 0, -1, 32'd0, -1, w);
        check("inv_fill_refetch", w, 32'd1);
        fetch(32'd33);

        // fence.i in IDLE on a hitting address.
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        #1;
        check("inv_idle_miss", {31'd0, im_miss}, 32'd1);
        check("inv_idle_noreq", {31'd0, mem_req_valid}, 32'd0);
        serve(32'd32, 0, 0, -1, 32'd0, -1, w);
        check("inv_idle_launch", w, 32'd1);
        fetch(32'd34);

        // Miss and fence.i in the same cycle: launch is deferred by one cycle.
        im_addr    = 32'd40;
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        #1;
        check("inv_miss_defer", {31'd0, mem_req_valid}, 32'd0);
        serve(32'd40, 0, 0, -1, 32'd0, -1, w);
        check("inv_miss_launch", w, 32'd1);
        fetch(32'd41);

        // Reset after two beats; stray beats afterwards must be ignored.
        im_addr = 32'd0;
        step();
        check("rmf_req_valid", {31'd0, mem_req_valid}, 32'd1);
        check("rmf_req_addr", mem_req_addr, 32'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(k);
            step();
        end
        rst          = 1'b1;
        mem_rsp_data = 32'hBAD0_0002;
        step();
        rst          = 1'b0;
        mem_rsp_data = 32'hBAD0_0003;
        #1;
        check("rmf_miss", {31'd0, im_miss}, 32'd1);
        check("rmf_idle_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rmf_idle_addr", mem_req_addr, 32'd0);
        step();
        mem_rsp_valid = 1'b0;
        #1;
        check("rmf_refetch_valid", {31'd0, mem_req_valid}, 32'd1);
        serve(32'd0, 0, 1, -1, 32'd0, -1, w);
        for (int i = 0; i < LW; i++) fetch(i);

        // Randomized fetch stream against a line-level model.
        model_valid = 1'b1;
        model_line  = 32'd0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                invalidate = 1'b1;
                step();
                invalidate  = 1'b0;
                model_valid = 1'b0;
            end
            if (model_valid && $urandom_range(0, 1) == 1)
                a = model_line * LW + $urandom_range(0, LW - 1);
            else
                a = $urandom_range(0, 127);
            if (model_valid && (a / LW) == model_line) begin
                im_addr = a;
                #1;
                check("rnd_no_req", {31'd0, mem_req_valid}, 32'd0);
                fetch(a);
            end else begin
                fetch_t e;
                im_addr = a;
                e.addr  = a;
                e.data  = mem_word(a);
                sb_q.push_back(e);
                serve(a - (a % LW), int'($urandom_range(0, 3)), 2, -1, 32'd0, -1, w);
                check("rnd_req_wait", w, 32'd1);
                wait_pop(3);
                model_valid = 1'b1;
                model_line  = a / LW;
            end
        end

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
